// File: rtl/rtds_pkg.sv
// Shared definitions for the RTDS Aurora link blocks (pre, post, rx_frame_monitor).
package rtds_pkg;

  // Receive framing FSM: a frame is one sequence word followed by payload words.
  typedef enum logic {
    S_SEQ     = 1'b0,
    S_PAYLOAD = 1'b1
  } rx_state_t;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_CNT_WIDTH   = 32;
  localparam int DEF_DELAY_WIDTH = 16;
  localparam int PAY_CNT_WIDTH   = 16;

  // Word position of the sequence number inside every frame.
  localparam int SEQ_WORD_IDX = 0;

  // Payload-length increment that sticks at all-ones instead of wrapping.
  function automatic logic [PAY_CNT_WIDTH-1:0] pay_cnt_inc(input logic [PAY_CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear that overrides the increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // Clear first, then increment unless already pinned at all-ones.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && !(&count_reg)) begin
      count_next = count_reg + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/rx_frame_monitor.sv
// Aurora RX frame monitor: checks sequence continuity and frame length, keeps
// saturating statistics and issues a delayed one-cycle TX trigger per frame.
module rx_frame_monitor
  import rtds_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int EXP_LEN     = 2,
  parameter int DELAY_WIDTH = DEF_DELAY_WIDTH
) (
  input  logic                   m_axis_aclk,
  input  logic                   m_axis_aresetn,
  input  logic                   s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic                   ctrl_en,
  input  logic [DELAY_WIDTH-1:0] ctrl_delay,
  input  logic                   ctrl_clear,
  output logic                   trig_pulse,
  output logic [CNT_WIDTH-1:0]   stat_frames,
  output logic [CNT_WIDTH-1:0]   stat_seq_err,
  output logic [CNT_WIDTH-1:0]   stat_len_err,
  output logic [DATA_WIDTH-1:0]  stat_last_seq,
  output logic                   stat_synced
);

  rx_state_t                state_reg, state_next;
  logic [PAY_CNT_WIDTH-1:0] pay_cnt_reg, pay_cnt_next;
  logic [PAY_CNT_WIDTH-1:0] frame_len;
  logic [DATA_WIDTH-1:0]    last_seq_reg, last_seq_next;
  logic [DATA_WIDTH-1:0]    seq_expect;
  logic                     synced_reg, synced_next;
  logic [DELAY_WIDTH-1:0]   dly_cnt_reg, dly_cnt_next;
  logic                     pend_reg, pend_next;
  logic                     trig_reg, trig_next;
  logic                     seq_beat, frame_end, seq_err, len_err;
  logic [2:0]               cnt_inc;
  logic [CNT_WIDTH-1:0]     cnt_val [3];

  // Beat classification and error detection; frame_len includes the current beat.
  always_comb begin
    seq_beat   = s_axis_tvalid && (state_reg == S_SEQ);
    frame_end  = s_axis_tvalid && s_axis_tlast;
    frame_len  = (state_reg == S_SEQ) ? '0 : pay_cnt_inc(pay_cnt_reg);
    seq_expect = last_seq_reg + 1'b1;
    seq_err    = seq_beat && synced_reg && (s_axis_tdata != seq_expect);
    len_err    = frame_end && (EXP_LEN != 0) && (frame_len != PAY_CNT_WIDTH'(EXP_LEN));
  end

  // Framing FSM next state and payload counter.
  always_comb begin
    state_next   = state_reg;
    pay_cnt_next = pay_cnt_reg;
    case (state_reg)
      S_SEQ: begin
        if (s_axis_tvalid) begin
          pay_cnt_next = '0;
          if (!s_axis_tlast) begin
            state_next = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (s_axis_tvalid) begin
          pay_cnt_next = frame_len;
          if (s_axis_tlast) begin
            state_next = S_SEQ;
          end
        end
      end
      default: state_next = S_SEQ;
    endcase
  end

  // Sequence tracking; clear overrides a same-cycle capture.
  always_comb begin
    last_seq_next = last_seq_reg;
    synced_next   = synced_reg;
    if (ctrl_clear) begin
      last_seq_next = '0;
      synced_next   = 1'b0;
    end else if (seq_beat) begin
      last_seq_next = s_axis_tdata;
      synced_next   = 1'b1;
    end
  end

  // Trigger delay: a zero delay fires straight from frame end, otherwise the
  // counter is loaded with delay-1 so the pulse lands delay+1 cycles after tlast.
  always_comb begin
    dly_cnt_next = dly_cnt_reg;
    pend_next    = pend_reg;
    trig_next    = 1'b0;
    if (frame_end && ctrl_en) begin
      if (ctrl_delay == '0) begin
        trig_next = 1'b1;
        pend_next = 1'b0;
      end else begin
        dly_cnt_next = ctrl_delay - 1'b1;
        pend_next    = 1'b1;
      end
    end else if (pend_reg) begin
      if (!ctrl_en) begin
        pend_next = 1'b0;
      end else if (dly_cnt_reg == '0) begin
        trig_next = 1'b1;
        pend_next = 1'b0;
      end else begin
        dly_cnt_next = dly_cnt_reg - 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_reg    <= S_SEQ;
      pay_cnt_reg  <= '0;
      last_seq_reg <= '0;
      synced_reg   <= 1'b0;
      dly_cnt_reg  <= '0;
      pend_reg     <= 1'b0;
      trig_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pay_cnt_reg  <= pay_cnt_next;
      last_seq_reg <= last_seq_next;
      synced_reg   <= synced_next;
      dly_cnt_reg  <= dly_cnt_next;
      pend_reg     <= pend_next;
      trig_reg     <= trig_next;
    end
  end

  // Statistics: [0] frames, [1] sequence errors, [2] length errors.
  assign cnt_inc = {len_err, seq_err, frame_end};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      sat_counter #(
        .WIDTH(CNT_WIDTH)
      ) u_cnt (
        .clk  (m_axis_aclk),
        .rst_n(m_axis_aresetn),
        .clr  (ctrl_clear),
        .inc  (cnt_inc[gi]),
        .count(cnt_val[gi])
      );
    end
  endgenerate

  assign stat_frames   = cnt_val[0];
  assign stat_seq_err  = cnt_val[1];
  assign stat_len_err  = cnt_val[2];
  assign stat_last_seq = last_seq_reg;
  assign stat_synced   = synced_reg;
  assign trig_pulse    = trig_reg;

endmodule
